io_pipes_tx_arbiter: RTL and testbench
======================================

# io_pipes_tx_arbiter

Packet-aware round-robin arbiter that merges the per-channel I/O-pipe Avalon-ST egress streams from the kernel system onto a single shared egress stream toward the shim/host-side transport. Each packet (sop..eop) is granted atomically; the source channel ID is tagged on every output beat. It sits between the kernel-wrapper I/O-pipe ports and the shared egress interface, in the kernel-side clock domain.

## Interface
- NUM_CHAN, 16: number of I/O-pipe channels (matches IO_PIPES_NUM_CHAN).
- DATA_W, 64: beat width (matches SHIM_AVST_DATA_WIDTH).
- CHAN_W, $clog2(NUM_CHAN): channel-ID width; derived, not overridden.

- clk  in  1  block clock; all logic single-domain.
- reset  in  1  synchronous, active-high reset.
- ch_enable  in  NUM_CHAN  per-channel arbitration enable mask (quasi-static CSR).
- in_valid  in  NUM_CHAN  per-channel beat valid.
- in_data  in  NUM_CHAN×DATA_W  per-channel beat data.
- in_sop  in  NUM_CHAN  per-channel start-of-packet.
- in_eop  in  NUM_CHAN  per-channel end-of-packet.
- in_ready  out  NUM_CHAN  per-channel ready; at most one bit set.
- out_valid  out  1  merged beat valid.
- out_data  out  DATA_W  merged beat data.
- out_sop  out  1  merged start-of-packet.
- out_eop  out  1  merged end-of-packet.
- out_chan  out  CHAN_W  source channel of current beat.
- out_ready  in  1  downstream ready.
- busy  out  1  high while in LOCKED.
- sop_err  out  1  one-cycle pulse on framing error.

## Operation
- States: IDLE, LOCKED.
- IDLE: request vector = in_valid & ch_enable. If non-zero, pick first set bit searching upward from (last_grant+1) mod NUM_CHAN; register grant and last_grant, go to LOCKED. No in_ready asserted in IDLE.
- LOCKED: in_ready[grant] = skid buffer not full (registered flag). Beat accepted when in_valid[grant] & in_ready[grant]; pushed into skid buffer with chan=grant. Accepted beat with eop → IDLE next cycle.
- ch_enable changes affect only the next IDLE decision; a locked packet always runs to eop.
- Framing: first accepted beat of a grant without sop, or non-first beat with sop → sop_err pulse the cycle after acceptance; beat still forwarded unchanged.
- Single-beat packet (sop&eop): legal, one beat then IDLE.
- Output: 2-entry skid buffer; out_* driven from head entry; pop on out_valid & out_ready. in_ready has no combinational path from out_ready.

## Timing
- Reset: state=IDLE, last_grant=NUM_CHAN-1 (channel 0 highest priority first), skid empty, in_ready=0, out_valid=0, out_sop/out_eop/out_chan/out_data=0, busy=0, sop_err=0. Reset mid-packet truncates; no residual beats emitted.
- Arbitration: request seen in cycle N → in_ready[grant] asserted cycle N+1.
- Data latency: beat accepted at cycle N → out_valid at N+1 (if skid was empty).
- Throughput: N-beat packet occupies N+1 cycles (one IDLE bubble per packet) with out_ready held high.
- Backpressure: out_ready low ≥2 cycles fills skid; in_ready drops the cycle after fill; no beat lost or duplicated. Simultaneous push and pop when full-minus-one keeps in_ready high.
- Round-robin wrap: after grant to NUM_CHAN-1, search starts at 0.

## Structure
- dc_bsp_pkg additions: typedef t_io_pipe_beat struct {data[DATA_W], sop, eop, chan[CHAN_W]}; state enum t_io_arb_state {IDLE, LOCKED}.
- One sub-module: io_pipe_skid_buf (2-entry, parameterized on t_io_pipe_beat width; push/pop/full/empty).
- Round-robin pick as a local function in the top module.

## Test plan
- Reset then ch 3 sends 4-beat packet (sop on beat 0, eop on beat 3), out_ready=1 → out beats 0..3, out_chan=3, in_ready[3] high cycles 1–4, busy low at cycle 6.
- Ch 0, 5, 15 all valid continuously with 2-beat packets → grant order 0,5,15,0,5,15; each packet on output contiguous, never interleaved.
- ch_enable[5]=0 with ch 5 and 7 valid → only ch 7 granted; clear ch_enable[7] mid-packet → packet completes through eop, then IDLE with no further grants.
- out_ready toggled 1,0,0,0,1 during 8-beat packet from ch 2 → all 8 beats emitted in order, none duplicated; in_ready[2] low while skid full.
- Ch 1 first beat without sop → sop_err pulses once, beat still forwarded with out_sop=0; also test sop mid-packet → sop_err pulse.
- Assert reset on beat 2 of 5-beat packet from ch 9 → next cycle out_valid=0, in_ready=0; after release ch 0 and 9 both valid → ch 0 granted first.

Source files
------------

// File: rtl/io_pipes_tx_arbiter_pkg.sv
// Shared types for the I/O-pipe egress arbiter: the beat carried through the
// output skid buffer and the arbiter state encoding.
package io_pipes_tx_arbiter_pkg;

  localparam int IO_NUM_CHAN = 16;
  localparam int IO_DATA_W   = 64;
  localparam int IO_CHAN_W   = $clog2(IO_NUM_CHAN);

  typedef struct packed {
    logic [IO_DATA_W-1:0] data;
    logic                 sop;
    logic                 eop;
    logic [IO_CHAN_W-1:0] chan;
  } t_io_pipe_beat;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } t_io_arb_state;

endpackage

// File: rtl/io_pipe_skid_buf.sv
// Two-entry skid buffer decoupling the arbiter from downstream backpressure.
// full/empty are registered so the upstream ready never depends on out_ready.
module io_pipe_skid_buf
  import io_pipes_tx_arbiter_pkg::*;
#(
  parameter int WIDTH = $bits(t_io_pipe_beat)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 2'd1;
    end else if (!do_push && do_pop) begin
      count_nxt = count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_nxt;
      full  <= (count_nxt == 2'd2);
      empty <= (count_nxt == 2'd0);
    end
  end

endmodule

// File: rtl/io_pipes_tx_arbiter.sv
// Packet-atomic round-robin merge of the per-channel I/O-pipe egress streams
// onto one shared stream, tagging each beat with its source channel.
module io_pipes_tx_arbiter
  import io_pipes_tx_arbiter_pkg::*;
#(
  parameter  int NUM_CHAN = IO_NUM_CHAN,
  parameter  int DATA_W   = IO_DATA_W,
  localparam int CHAN_W   = $clog2(NUM_CHAN)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CHAN-1:0]        ch_enable,
  input  logic [NUM_CHAN-1:0]        in_valid,
  input  logic [NUM_CHAN*DATA_W-1:0] in_data,
  input  logic [NUM_CHAN-1:0]        in_sop,
  input  logic [NUM_CHAN-1:0]        in_eop,
  output logic [NUM_CHAN-1:0]        in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [CHAN_W-1:0]          out_chan,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       sop_err
);

  localparam int BEAT_W = DATA_W + 2 + CHAN_W;

  // First requester strictly after 'last', wrapping; scanning downward lets
  // the closest candidate overwrite the farther ones.
  function automatic logic [CHAN_W-1:0] rr_pick(input logic [NUM_CHAN-1:0] req,
                                                input logic [CHAN_W-1:0]   last);
    logic [CHAN_W-1:0] pick;
    int                idx;
    pick = last;
    for (int k = NUM_CHAN; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_CHAN;
      if (req[idx]) begin
        pick = CHAN_W'(idx);
      end
    end
    return pick;
  endfunction

  t_io_arb_state     state;
  t_io_arb_state     state_nxt;
  logic [CHAN_W-1:0] grant;
  logic [CHAN_W-1:0] grant_nxt;
  logic [CHAN_W-1:0] last_grant;
  logic              first_beat;
  logic [NUM_CHAN-1:0] req;
  logic              accept;
  logic              frame_err;
  logic              skid_full;
  logic              skid_empty;
  logic [BEAT_W-1:0] push_beat;
  logic [BEAT_W-1:0] head_beat;

  assign req       = in_valid & ch_enable;
  assign accept    = (state == LOCKED) && in_valid[grant] && !skid_full;
  assign frame_err = accept && (first_beat != in_sop[grant]);
  assign push_beat = {in_data[int'(grant)*DATA_W +: DATA_W], in_sop[grant], in_eop[grant], grant};
  assign busy      = (state == LOCKED);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = LOCKED;
          grant_nxt = rr_pick(req, last_grant);
        end
      end
      LOCKED: begin
        if (accept && in_eop[grant]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = '0;
    if (state == LOCKED) begin
      in_ready[grant] = !skid_full;
    end
  end

  // last_grant starts at the top channel so channel 0 wins the first decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CHAN_W'(NUM_CHAN - 1);
      first_beat <= 1'b0;
      sop_err    <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      sop_err <= frame_err;
      if (state == IDLE && |req) begin
        last_grant <= grant_nxt;
        first_beat <= 1'b1;
      end else if (accept) begin
        first_beat <= 1'b0;
      end
    end
  end

  io_pipe_skid_buf #(
    .WIDTH(BEAT_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .push_data(push_beat),
    .pop      (out_valid && out_ready),
    .head     (head_beat),
    .full     (skid_full),
    .empty    (skid_empty)
  );

  // Stale head contents are masked so idle outputs read as zero.
  assign out_valid = !skid_empty;
  assign {out_data, out_sop, out_eop, out_chan} = skid_empty ? '0 : head_beat;

endmodule

// File: tb/tb_io_pipes_tx_arbiter.sv
// Scoreboard bench for io_pipes_tx_arbiter: a packet-level round-robin model
// fills an expected-beat queue; a separate monitor checks every output beat.
module tb_io_pipes_tx_arbiter;
  import io_pipes_tx_arbiter_pkg::*;

  localparam int NC = 16;
  localparam int DW = 64;
  localparam int CW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } in_beat_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC-1:0]    ch_enable;
  logic [NC-1:0]    in_valid;
  logic [NC*DW-1:0] in_data;
  logic [NC-1:0]    in_sop;
  logic [NC-1:0]    in_eop;
  logic [NC-1:0]    in_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_sop;
  logic             out_eop;
  logic [CW-1:0]    out_chan;
  logic             out_ready;
  logic             busy;
  logic             sop_err;

  always #5 clk = ~clk;

  io_pipes_tx_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .ch_enable(ch_enable),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_chan (out_chan),
    .out_ready(out_ready),
    .busy     (busy),
    .sop_err  (sop_err)
  );

  in_beat_t      chan_q [NC][$];
  t_io_pipe_beat exp_q[$];
  int            compared   = 0;
  int            mismatched = 0;
  int            model_last = NC - 1;
  int            exp_err    = 0;
  int            obs_err    = 0;
  int            cyc        = 0;
  int            occ        = 0;
  int            max_occ    = 0;
  int            or_mode    = 0;
  logic          rst_drive  = 1'b1;
  logic [NC-1:0] en_drive   = '1;
  logic [NC-1:0] acc_mask   = '0;
  logic          pop_prev   = 1'b0;
  logic          rst_prev   = 1'b1;

  task automatic check_output(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every handshaken output beat must be the next expected beat.
  always @(negedge clk) begin
    t_io_pipe_beat got;
    t_io_pipe_beat e;
    #1;
    if (sop_err === 1'b1) obs_err++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      got.data = out_data;
      got.sop  = out_sop;
      got.eop  = out_eop;
      got.chan = out_chan;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL beat_unexpected: got chan=%0d data=%h, expected no beat", out_chan, out_data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          mismatched++;
          $display("[TB] FAIL beat: got chan=%0d sop=%b eop=%b data=%h expected chan=%0d sop=%b eop=%b data=%h",
                   got.chan, got.sop, got.eop, got.data, e.chan, e.sop, e.eop, e.data);
        end
      end
    end
  end

  // One clock of stimulus: retire beats accepted at the last edge, then drive.
  task automatic apply_stimulus();
    @(negedge clk);
    cyc++;
    for (int c = 0; c < NC; c++) begin
      if (acc_mask[c] && chan_q[c].size() > 0) void'(chan_q[c].pop_front());
    end
    if (rst_prev) occ = 0;
    else occ = occ + $countones(acc_mask) - int'(pop_prev);
    if (occ > max_occ) max_occ = occ;
    reset     = rst_drive;
    ch_enable = en_drive;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(3) != 0);
      default: out_ready = (cyc % 5 == 0) || (cyc % 5 == 4);
    endcase
    for (int c = 0; c < NC; c++) begin
      if (chan_q[c].size() > 0) begin
        in_valid[c]            = 1'b1;
        in_data[c*DW +: DW]    = chan_q[c][0].data;
        in_sop[c]              = chan_q[c][0].sop;
        in_eop[c]              = chan_q[c][0].eop;
      end else begin
        in_valid[c]            = 1'b0;
        in_data[c*DW +: DW]    = {$urandom, $urandom};
        in_sop[c]              = 1'b0;
        in_eop[c]              = 1'b0;
      end
    end
    acc_mask = reset ? '0 : (in_valid & in_ready);
    pop_prev = !reset && out_valid && out_ready;
    rst_prev = reset;
    if (occ >= 2 && !reset) check_output("in_ready_while_full", in_ready, 0);
    if (occ > 2) check_output("occupancy_bound", occ, 2);
  endtask

  task automatic load_packet(input int ch, input int len, input int bad_sop_at);
    in_beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.sop  = (i == 0);
      if (i == bad_sop_at) b.sop = ~b.sop;
      b.eop  = (i == len - 1);
      chan_q[ch].push_back(b);
    end
  endtask

  // Packet-level reference: whole packets are handed out round-robin among
  // enabled channels that still hold packets, starting after the last winner.
  task automatic model_plan(input logic [NC-1:0] mask);
    int            pos[NC];
    int            cc;
    bit            found;
    bit            first;
    in_beat_t      b;
    t_io_pipe_beat e;
    for (int c = 0; c < NC; c++) pos[c] = 0;
    for (int guard = 0; guard < 1000; guard++) begin
      found = 0;
      cc    = 0;
      for (int k = 1; k <= NC && !found; k++) begin
        cc = (model_last + k) % NC;
        if (mask[cc] && pos[cc] < chan_q[cc].size()) found = 1;
      end
      if (!found) break;
      first = 1;
      while (pos[cc] < chan_q[cc].size()) begin
        b = chan_q[cc][pos[cc]];
        pos[cc]++;
        if (b.sop != first) exp_err++;
        e.data = b.data;
        e.sop  = b.sop;
        e.eop  = b.eop;
        e.chan = CW'(cc);
        exp_q.push_back(e);
        first = 0;
        if (b.eop) break;
      end
      model_last = cc;
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin
      apply_stimulus();
      guard++;
    end
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_drain_timeout: got %0d beats outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) apply_stimulus();
    check_output({name, "_sop_err_count"}, obs_err, exp_err);
    check_output({name, "_busy_after"}, busy, 0);
  endtask

  task automatic do_reset();
    rst_drive = 1'b1;
    for (int c = 0; c < NC; c++) chan_q[c].delete();
    exp_q.delete();
    apply_stimulus();
    apply_stimulus();
    rst_drive  = 1'b0;
    model_last = NC - 1;
    exp_err    = 0;
    obs_err    = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    int len;
    int n;
    logic [NC-1:0] mask;

    reset = 1'b1; ch_enable = '1; in_valid = '0; in_data = '0;
    in_sop = '0; in_eop = '0; out_ready = 1'b0;

    do_reset();
    apply_stimulus();
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_sop_err", sop_err, 0);
    check_output("rst_out_fields", {out_sop, out_eop, out_chan}, 0);
    check_output("rst_out_data", out_data, 0);

    // Single 4-beat packet from channel 3 with timing of ready/valid/busy.
    load_packet(3, 4, -1);
    model_plan(en_drive);
    for (int k = 0; k <= 6; k++) begin
      apply_stimulus();
      if (k >= 1 && k <= 4) check_output("t1_in_ready_on", in_ready, 16'h0008);
      else check_output("t1_in_ready_off", in_ready, 0);
      if (k == 2) check_output("t1_out_latency", out_valid, 1);
      if (k == 6) check_output("t1_busy_low", busy, 0);
    end
    drain("t1");

    // Three contending channels, two 2-beat packets each.
    exp_err = 0; obs_err = 0;
    for (int p = 0; p < 2; p++) begin
      load_packet(0, 2, -1);
      load_packet(5, 2, -1);
      load_packet(15, 2, -1);
    end
    model_plan(en_drive);
    drain("t2");

    // Masked channel and enable removal mid-packet.
    do_reset();
    en_drive = 16'hFFDF;
    load_packet(5, 3, -1);
    load_packet(7, 4, -1);
    model_plan(en_drive);
    guard = 0;
    while (chan_q[7].size() > 2 && guard < 100) begin
      apply_stimulus();
      guard++;
    end
    en_drive[7] = 1'b0;
    load_packet(7, 3, -1);
    drain("t3");
    for (int k = 0; k < 4; k++) begin
      apply_stimulus();
      check_output("t3_no_grant", {busy, in_ready}, 0);
    end
    do_reset();
    en_drive = '1;

    // Backpressure during an 8-beat packet.
    max_occ = 0;
    or_mode = 2;
    load_packet(2, 8, -1);
    model_plan(en_drive);
    drain("t4");
    check_output("t4_skid_filled", max_occ, 2);
    or_mode = 0;

    // Framing errors: missing first sop, then sop in mid-packet.
    exp_err = 0; obs_err = 0;
    load_packet(1, 3, 0);
    load_packet(1, 4, 2);
    model_plan(en_drive);
    drain("t5");
    check_output("t5_err_total", obs_err, 2);

    // Reset in the middle of a 5-beat packet from channel 9.
    do_reset();
    load_packet(9, 5, -1);
    for (int i = 0; i < 3; i++) begin
      t_io_pipe_beat e;
      e.data = chan_q[9][i].data;
      e.sop  = chan_q[9][i].sop;
      e.eop  = chan_q[9][i].eop;
      e.chan = CW'(9);
      exp_q.push_back(e);
    end
    guard = 0;
    while (chan_q[9].size() > 3 && guard < 100) begin
      apply_stimulus();
      guard++;
    end
    rst_drive = 1'b1;
    apply_stimulus();
    for (int c = 0; c < NC; c++) chan_q[c].delete();
    rst_drive = 1'b0;
    apply_stimulus();
    check_output("t6_out_valid_after_rst", out_valid, 0);
    check_output("t6_in_ready_after_rst", in_ready, 0);
    check_output("t6_pre_reset_beats_seen", exp_q.size(), 0);
    exp_q.delete();
    model_last = NC - 1; exp_err = 0; obs_err = 0;
    load_packet(9, 2, -1);
    load_packet(0, 2, -1);
    model_plan(en_drive);
    drain("t6");

    // Randomized rounds with random masks, lengths, framing and backpressure.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      or_mode = 1;
      mask = '1;
      repeat ($urandom_range(3)) mask[$urandom_range(NC - 1)] = 1'b0;
      en_drive = mask;
      n = $urandom_range(3, 8);
      for (int i = 0; i < n; i++) begin
        int ch;
        ch = $urandom_range(NC - 1);
        for (int p = 0; p < int'($urandom_range(1, 2)); p++) begin
          len = $urandom_range(1, 6);
          load_packet(ch, len, ($urandom_range(9) == 0) ? int'($urandom_range(len - 1)) : -1);
        end
      end
      model_plan(mask);
      drain("rand");
    end
    or_mode  = 0;
    en_drive = '1;
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
